// File: rtl/sevenseg_capture.sv
// sevenseg_capture: recovers the hex digit shown on a remote seven-segment
// display by synchronising, filtering and decoding the segment lines.
//
// Ports:
//   clk            system clock (Sys_Clk0)
//   rst            synchronous active-high reset
//   a..g           raw segment lines, asynchronous to clk
//   digit          last accepted hex value
//   digit_valid    one-cycle strobe when a new pattern is accepted
//   pat_err        last accepted pattern is not a legal glyph
//   blank          last accepted pattern has every segment off
//   change_count   accepted changes, wraps 255->0
//   redled         low-true, lit while pat_err
//   greenled       low-true, lit while a legal digit is held
//   blueled        low-true, lit while blank

module sevenseg_capture #(
    parameter int STABLE_CYCLES = 1000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       pat_err,
    output logic       blank,
    output logic [7:0] change_count,
    output logic       redled,
    output logic       greenled,
    output logic       blueled
);

    localparam logic [15:0] L_STABLE = 16'(STABLE_CYCLES);
    localparam logic [15:0] L_LAST   = 16'(STABLE_CYCLES - 1);

    logic [6:0]  w_raw;
    logic [6:0]  w_pat;
    logic [6:0]  r_s1;
    logic [6:0]  r_s2;
    logic [6:0]  r_cand;
    logic [15:0] r_cnt;
    logic [6:0]  r_acc;
    logic        w_same;
    logic        w_accept;
    logic [3:0]  w_dec;
    logic        w_legal;
    logic [3:0]  r_digit;
    logic        r_valid;
    logic        r_err;
    logic        r_blank;
    logic [7:0]  r_count;

    // Internal pattern is always active-high, bit 0 = segment a.
    assign w_raw = {g, f, e, d, c, b, a};
    assign w_pat = ACTIVE_LOW ? ~w_raw : w_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 7'h00;
            r_s2 <= 7'h00;
        end else begin
            r_s1 <= w_pat;
            r_s2 <= r_s1;
        end
    end

    assign w_same = (r_s2 == r_cand);

    // Stability filter: any difference restarts the count, and the count
    // saturates so a settled pattern is offered for acceptance only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand <= 7'h00;
            r_cnt  <= 16'd0;
        end else if (!w_same) begin
            r_cand <= r_s2;
            r_cnt  <= 16'd0;
        end else if (r_cnt < L_STABLE) begin
            r_cnt  <= r_cnt + 16'd1;
        end
    end

    // Re-settling on the already accepted pattern is silent.
    assign w_accept = w_same && (r_cnt == L_LAST) && (r_cand != r_acc);

    always_comb begin
        w_dec   = 4'h0;
        w_legal = 1'b1;
        unique case (r_cand)
            7'h3F:   w_dec = 4'h0;
            7'h06:   w_dec = 4'h1;
            7'h5B:   w_dec = 4'h2;
            7'h4F:   w_dec = 4'h3;
            7'h66:   w_dec = 4'h4;
            7'h6D:   w_dec = 4'h5;
            7'h7D:   w_dec = 4'h6;
            7'h07:   w_dec = 4'h7;
            7'h7F:   w_dec = 4'h8;
            7'h6F:   w_dec = 4'h9;
            7'h77:   w_dec = 4'hA;
            7'h7C:   w_dec = 4'hB;
            7'h39:   w_dec = 4'hC;
            7'h5E:   w_dec = 4'hD;
            7'h79:   w_dec = 4'hE;
            7'h71:   w_dec = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= 7'h00;
            r_digit <= 4'h0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_blank <= 1'b1;
            r_count <= 8'd0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_acc   <= r_cand;
                r_valid <= 1'b1;
                r_count <= r_count + 8'd1;
                if (w_legal) begin
                    r_digit <= w_dec;
                    r_err   <= 1'b0;
                    r_blank <= 1'b0;
                end else if (r_cand == 7'h00) begin
                    r_err   <= 1'b0;
                    r_blank <= 1'b1;
                end else begin
                    r_err   <= 1'b1;
                    r_blank <= 1'b0;
                end
            end
        end
    end

    assign digit        = r_digit;
    assign digit_valid  = r_valid;
    assign pat_err      = r_err;
    assign blank        = r_blank;
    assign change_count = r_count;

    assign redled   = ~r_err;
    assign greenled = r_err | r_blank;
    assign blueled  = ~r_blank;

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture: directed self-checking bench for sevenseg_capture
// with STABLE_CYCLES=4 and active-low segment inputs.

module tb_sevenseg_capture;

    logic       clk;
    logic       rst;
    logic       a, b, c, d, e, f, g;
    logic [3:0] digit;
    logic       digit_valid;
    logic       pat_err;
    logic       blank;
    logic [7:0] change_count;
    logic       redled;
    logic       greenled;
    logic       blueled;

    int passed;
    int total;

    sevenseg_capture #(
        .STABLE_CYCLES(4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .c(c),
        .d(d),
        .e(e),
        .f(f),
        .g(g),
        .digit(digit),
        .digit_valid(digit_valid),
        .pat_err(pat_err),
        .blank(blank),
        .change_count(change_count),
        .redled(redled),
        .greenled(greenled),
        .blueled(blueled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] glyph [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Takes an active-high pattern {g..a}; the wires are low-true.
    task automatic set_pat(input logic [6:0] p);
        {g, f, e, d, c, b, a} = ~p;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Strobe must appear exactly 7 ticks after the drive (E0+4+2 edge).
    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (digit_valid !== 1'b1 && n < 20);
        chk({tag, "_latency"}, n, 7);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (digit_valid !== 1'b0) hits++;
        end
        chk({tag, "_no_strobe"}, hits, 0);
    endtask

    initial begin
        logic [7:0] exp_cc;
        int         saw_zero;
        passed = 0;
        total  = 0;
        glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B;
        glyph[3]  = 7'h4F; glyph[4]  = 7'h66; glyph[5]  = 7'h6D;
        glyph[6]  = 7'h7D; glyph[7]  = 7'h07; glyph[8]  = 7'h7F;
        glyph[9]  = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
        glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79;
        glyph[15] = 7'h71;

        rst = 1'b1;
        set_pat(7'h00);
        tick();
        tick();
        chk("rst_digit", digit, 4'h0);
        chk("rst_valid", digit_valid, 1'b0);
        chk("rst_err", pat_err, 1'b0);
        chk("rst_blank", blank, 1'b1);
        chk("rst_cc", change_count, 8'd0);
        chk("rst_red", redled, 1'b1);
        chk("rst_green", greenled, 1'b1);
        chk("rst_blue", blueled, 1'b0);
        rst = 1'b0;

        quiet("blank_after_rst", 12);
        chk("blank_after_rst_cc", change_count, 8'd0);

        // Test 1: digit 1, strobe on the 7th tick only.
        set_pat(7'h06);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("t1_dv_tick%0d", k), digit_valid,
                (k == 7) ? 1'b1 : 1'b0);
            if (k == 7) begin
                chk("t1_digit", digit, 4'h1);
                chk("t1_cc", change_count, 8'd1);
                chk("t1_green", greenled, 1'b0);
                chk("t1_err", pat_err, 1'b0);
                chk("t1_blank", blank, 1'b0);
            end
        end

        // Test 2: 3-cycle glitch to 8 is rejected.
        set_pat(7'h7F);
        tick(); tick(); tick();
        set_pat(7'h06);
        quiet("t2_glitch", 12);
        chk("t2_digit", digit, 4'h1);
        chk("t2_cc", change_count, 8'd1);

        for (int i = 0; i < 16; i++) begin
            set_pat(glyph[i]);
            wait_strobe($sformatf("sweep%0d", i));
            chk($sformatf("sweep%0d_digit", i), digit, i);
        end
        chk("sweep_cc", change_count, 8'd17);

        // Test 3: illegal pattern, then back to a legal glyph.
        set_pat(7'h49);
        wait_strobe("t3_bad");
        chk("t3_err", pat_err, 1'b1);
        chk("t3_red", redled, 1'b0);
        chk("t3_green", greenled, 1'b1);
        chk("t3_blank", blank, 1'b0);
        chk("t3_digit_held", digit, 4'hF);
        set_pat(7'h5B);
        wait_strobe("t3_good");
        chk("t3_err_clr", pat_err, 1'b0);
        chk("t3_red_off", redled, 1'b1);
        chk("t3_digit2", digit, 4'h2);
        chk("t3_cc", change_count, 8'd19);

        // Test 4: re-presenting the accepted pattern is silent.
        set_pat(7'h3F);
        tick(); tick();
        set_pat(7'h5B);
        quiet("t4_repeat", 12);
        chk("t4_cc_hold", change_count, 8'd19);

        set_pat(7'h00);
        wait_strobe("t4_blank");
        chk("t4_blank", blank, 1'b1);
        chk("t4_blue", blueled, 1'b0);
        chk("t4_green", greenled, 1'b1);
        chk("t4_digit_held", digit, 4'h2);
        chk("t4_cc", change_count, 8'd20);

        exp_cc   = 8'd20;
        saw_zero = 0;
        for (int i = 0; i < 256; i++) begin
            set_pat((i % 2 == 0) ? 7'h06 : 7'h3F);
            wait_strobe($sformatf("alt%0d", i));
            exp_cc = exp_cc + 8'd1;
            chk($sformatf("alt%0d_cc", i), change_count, exp_cc);
            if (change_count === 8'd0) saw_zero++;
        end
        chk("wrap_seen", saw_zero, 1);
        chk("wrap_cc", change_count, 8'd20);
        chk("wrap_digit", digit, 4'h0);

        // Test 5: reset lands on what would be the accept edge.
        set_pat(7'h6D);
        for (int k = 0; k < 6; k++) tick();
        chk("t5_pre_dv", digit_valid, 1'b0);
        rst = 1'b1;
        tick();
        chk("t5_dv", digit_valid, 1'b0);
        chk("t5_digit", digit, 4'h0);
        chk("t5_err", pat_err, 1'b0);
        chk("t5_blank", blank, 1'b1);
        chk("t5_cc", change_count, 8'd0);
        chk("t5_red", redled, 1'b1);
        chk("t5_green", greenled, 1'b1);
        chk("t5_blue", blueled, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_after_dv", digit_valid, 1'b0);
        chk("t5_after_cc", change_count, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
